yacc_sb_writeback_unpacker: RTL and testbench

- Eviction-side counterpart of the YACC superblock packer.
- Takes one evicted superblock entry (SB tag, 512-bit data word, compression factor, set index) from the cache.
- Emits each resident 64-byte block as a separate uncompressed line with its full byte address, toward the memory/write-back path.
- One superblock in flight; valid/ready on both sides.

---
 rtl/yacc_sb_writeback_unpacker.sv | 184 ++++++++++++++++++
 tb/tb_yacc_sb_writeback_unpacker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/yacc_sb_writeback_unpacker.sv
// YACC superblock write-back unpacker: splits one evicted superblock into lines.
// Optional YACC_WB_STATS_EN adds line and superblock counters.
module yacc_sb_writeback_unpacker #(
  parameter int DATA_W  = 512,
  parameter int TAG_W   = 21,
  parameter int INDEX_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_cf,
  input  logic [TAG_W+3:0]   in_sbtag,
  input  logic [1:0]         in_half_vld,
  input  logic [INDEX_W-1:0] in_index,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_addr,
  output logic [DATA_W-1:0]  out_data,
  output logic               sb_done
`ifdef YACC_WB_STATS_EN
  ,
  output logic [31:0]        wb_line_cnt,
  output logic [31:0]        wb_sb_cnt
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state;
  logic [3:0]         pend;
  logic [1:0]         cf_q;
  logic [3:0]         fld_q;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic [DATA_W-1:0]  data_q;

  logic [3:0]         in_mask;
  logic [1:0]         src_cf;
  logic [3:0]         src_fld;
  logic [TAG_W-1:0]   src_tag;
  logic [INDEX_W-1:0] src_idx;
  logic [DATA_W-1:0]  src_data;
  logic [3:0]         src_mask;
  logic [3:0]         low;
  logic [3:0]         rest;
  logic [1:0]         k;
  logic [1:0]         blk;
  logic [DATA_W-1:0]  ldata;
  logic [31:0]        laddr;

  assign in_ready = (state == IDLE);

  always_comb begin
    in_mask = 4'b0000;
    unique case (in_cf)
      2'b00:   in_mask = 4'b0001;
      2'b01:   in_mask = {2'b00, in_half_vld};
      2'b10:   in_mask = in_sbtag[3:0];
      default: in_mask = 4'b0000;
    endcase
  end

  // In IDLE the first line is built straight from the inputs so it
  // appears one cycle after acceptance; later lines use captured state.
  always_comb begin
    if (state == IDLE) begin
      src_cf   = in_cf;
      src_fld  = in_sbtag[3:0];
      src_tag  = in_sbtag[TAG_W+3:4];
      src_idx  = in_index;
      src_data = in_data;
      src_mask = in_mask;
    end else begin
      src_cf   = cf_q;
      src_fld  = fld_q;
      src_tag  = tag_q;
      src_idx  = idx_q;
      src_data = data_q;
      src_mask = pend;
    end
  end

  assign low  = src_mask & (~src_mask + 4'd1);
  assign rest = src_mask & ~low;

  always_comb begin
    k = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (src_mask[i]) k = 2'(i);
  end

  always_comb begin
    blk   = src_fld[3:2];
    ldata = src_data;
    unique case (src_cf)
      2'b01: begin
        if (k[0]) begin
          blk   = src_fld[3:2];
          ldata = {{(DATA_W-256){1'b0}}, src_data[511:256]};
        end else begin
          blk   = src_fld[1:0];
          ldata = {{(DATA_W-256){1'b0}}, src_data[255:0]};
        end
      end
      2'b10: begin
        blk   = k;
        ldata = {{(DATA_W-128){1'b0}}, src_data[{k, 7'b0} +: 128]};
      end
      default: begin
        blk   = src_fld[3:2];
        ldata = src_data;
      end
    endcase
  end

  assign laddr = {src_tag, src_idx, blk, 6'b0};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= 4'b0;
      cf_q      <= 2'b0;
      fld_q     <= 4'b0;
      tag_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      out_valid <= 1'b0;
      out_addr  <= 32'b0;
      out_data  <= '0;
      sb_done   <= 1'b0;
    end else begin
      sb_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cf_q   <= in_cf;
            fld_q  <= in_sbtag[3:0];
            tag_q  <= in_sbtag[TAG_W+3:4];
            idx_q  <= in_index;
            data_q <= in_data;
            if (in_mask != 4'b0) begin
              out_valid <= 1'b1;
              out_addr  <= laddr;
              out_data  <= ldata;
              pend      <= rest;
              state     <= EMIT;
            end else begin
              sb_done <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (pend != 4'b0) begin
              out_addr <= laddr;
              out_data <= ldata;
              pend     <= rest;
            end else begin
              out_valid <= 1'b0;
              sb_done   <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef YACC_WB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_line_cnt <= 32'b0;
      wb_sb_cnt   <= 32'b0;
    end else begin
      if (out_valid && out_ready) wb_line_cnt <= wb_line_cnt + 32'd1;
      if (sb_done) wb_sb_cnt <= wb_sb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_yacc_sb_writeback_unpacker.sv
// Directed bench for yacc_sb_writeback_unpacker.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_yacc_sb_writeback_unpacker;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_cf;
  logic [24:0]  in_sbtag;
  logic [1:0]   in_half_vld;
  logic [2:0]   in_index;
  logic [511:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_addr;
  logic [511:0] out_data;
  logic         sb_done;
`ifdef YACC_WB_STATS_EN
  logic [31:0]  wb_line_cnt;
  logic [31:0]  wb_sb_cnt;
`endif

  int n_chk = 0;
  int n_ok  = 0;

  yacc_sb_writeback_unpacker dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cf       (in_cf),
    .in_sbtag    (in_sbtag),
    .in_half_vld (in_half_vld),
    .in_index    (in_index),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .sb_done     (sb_done)
`ifdef YACC_WB_STATS_EN
    ,
    .wb_line_cnt (wb_line_cnt),
    .wb_sb_cnt   (wb_sb_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] cf, input logic [24:0] tag,
                      input logic [1:0] hv, input logic [2:0] idx,
                      input logic [511:0] d);
    in_valid    = 1'b1;
    in_cf       = cf;
    in_sbtag    = tag;
    in_half_vld = hv;
    in_index    = idx;
    in_data     = d;
    step();
    in_valid = 1'b0;
  endtask

  logic [511:0] d0, d1, d2, d3;
  logic [255:0] ha, hb;
  logic [127:0] s0, s1, s2, s3;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_cf = 2'b0; in_sbtag = '0; in_half_vld = 2'b0;
    in_index = 3'b0; in_data = '0;
    for (int i = 0; i < 16; i++) d0[32*i +: 32] = 32'h1000_0000 + i;
    ha = {64{4'hA}};
    hb = {64{4'hB}};
    d1 = {ha, hb};
    s0 = {4{32'hC0DE_0000}};
    s1 = {4{32'hC0DE_0001}};
    s2 = {4{32'hC0DE_0002}};
    s3 = {4{32'hC0DE_0003}};
    d2 = {s3, s2, s1, s0};
    d3 = d2;
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sb_done", sb_done, 0);
    step();

    // CF=00 single line
    send(2'b00, {21'h0ABCD, 4'b1000}, 2'b00, 3'd5, d0);
    chk("cf0_valid", out_valid, 1);
    chk("cf0_addr", out_addr, 32'h055E6D80);
    chk("cf0_data", out_data, d0);
    chk("cf0_in_ready", in_ready, 0);
    chk("cf0_done_early", sb_done, 0);
    step();
    chk("cf0_valid_drop", out_valid, 0);
    chk("cf0_done", sb_done, 1);
    chk("cf0_ready_back", in_ready, 1);
    step();
    chk("cf0_done_pulse", sb_done, 0);

    // CF=01 two halves, back to back
    send(2'b01, {21'h0ABCD, 4'b1101}, 2'b11, 3'd5, d1);
    chk("cf1_l0_valid", out_valid, 1);
    chk("cf1_l0_addr", out_addr, 32'h055E6D40);
    chk("cf1_l0_data", out_data, {256'b0, hb});
    step();
    chk("cf1_l1_valid", out_valid, 1);
    chk("cf1_l1_addr", out_addr, 32'h055E6DC0);
    chk("cf1_l1_data", out_data, {256'b0, ha});
    chk("cf1_l1_done", sb_done, 0);
    step();
    chk("cf1_valid_drop", out_valid, 0);
    chk("cf1_done", sb_done, 1);

    // CF=10 slots 1 and 3 with a two-cycle stall
    send(2'b10, {21'h00001, 4'b1010}, 2'b00, 3'd2, d2);
    chk("cf2_l0_addr", out_addr, 32'h00000A40);
    chk("cf2_l0_data", out_data, {384'b0, s1});
    step();
    out_ready = 1'b0;
    chk("cf2_l1_addr", out_addr, 32'h00000AC0);
    chk("cf2_l1_data", out_data, {384'b0, s3});
    step();
    chk("cf2_stall_valid", out_valid, 1);
    chk("cf2_stall_addr", out_addr, 32'h00000AC0);
    chk("cf2_stall_data", out_data, {384'b0, s3});
    step();
    out_ready = 1'b1;
    chk("cf2_stall2_addr", out_addr, 32'h00000AC0);
    chk("cf2_stall2_done", sb_done, 0);
    step();
    chk("cf2_valid_drop", out_valid, 0);
    chk("cf2_done", sb_done, 1);
    step();

    // Empty masks, second accepted in the sb_done cycle
    send(2'b10, {21'h00002, 4'b0000}, 2'b00, 3'd1, d2);
    chk("e0_valid", out_valid, 0);
    chk("e0_done", sb_done, 1);
    chk("e0_in_ready", in_ready, 1);
    send(2'b01, {21'h00002, 4'b1111}, 2'b00, 3'd1, d1);
    chk("e1_valid", out_valid, 0);
    chk("e1_done", sb_done, 1);
    chk("e1_in_ready", in_ready, 1);
    step();
    chk("e1_done_pulse", sb_done, 0);

`ifdef YACC_WB_STATS_EN
    chk("stat_lines", wb_line_cnt, 5);
    chk("stat_sbs", wb_sb_cnt, 5);
`endif

    // Reset while the second line of a full CF=10 mask is shown
    send(2'b10, {21'h1FFFFF, 4'b1111}, 2'b00, 3'd7, d3);
    chk("rs_l0_addr", out_addr, 32'hFFFFFF00);
    chk("rs_l0_data", out_data, {384'b0, s0});
    step();
    chk("rs_l1_addr", out_addr, 32'hFFFFFF40);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rs_valid", out_valid, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_done", sb_done, 0);
`ifdef YACC_WB_STATS_EN
    chk("rs_stat_lines", wb_line_cnt, 0);
`endif
    step();
    chk("rs_post_valid", out_valid, 0);
    chk("rs_post_done", sb_done, 0);
    step();
    chk("rs_post2_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
